// File: rtl/seq_detect_ctrl_pkg.sv
// rtl/seq_detect_ctrl_pkg.sv - shared state type, default sizes and config length check
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic len_legal(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// rtl/seq_detect_ctrl_if.sv - config, control and serial stream bundle of the detector
interface seq_detect_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               cfg_err;
  logic               start;
  logic               abort;
  logic               in_valid;
  logic               in_bit;
  logic               busy;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, in_valid, in_bit,
    input  cfg_ready, cfg_err, busy, match, match_count, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, in_valid, in_bit,
    output cfg_ready, cfg_err, busy, match, match_count, done
  );

endinterface

// File: rtl/seq_detect_ctrl_shift_cmp.sv
// rtl/seq_detect_ctrl_shift_cmp.sv - bit history, fill counter and length-masked pattern compare
module seq_shift_cmp #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic               bit_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  output logic               hit_next_o
);

  localparam logic [LEN_W-1:0] SEEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   seen_q, seen_d;
  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_i));
    end
  end

  // hit is judged on the history as it will look after this bit lands
  always_comb begin
    hist_d = {hist_q[MAX_LEN-2:0], bit_i};
    seen_d = (seen_q == SEEN_MAX) ? seen_q : seen_q + 1'b1;
  end

  assign hit_next_o = shift_i && (seen_d >= len_i) &&
                      (((hist_d ^ pattern_i) & mask) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      seen_q <= '0;
    end else if (clear_i) begin
      hist_q <= '0;
      seen_q <= '0;
    end else if (shift_i) begin
      hist_q <= hist_d;
      seen_q <= seen_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial pattern detector: config latch, run FSM, match counter
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst,
  seq_detect_ctrl_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_e             state_q, state_d;
  logic               cfg_loaded_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   tgt_q;
  logic               cfg_err_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               match_q, match_d;
  logic               hist_clear;
  logic               shift_en;
  logic               hit_next;
  logic               cfg_acc;
  logic               cfg_ok;

  assign cfg_acc  = bus.cfg_valid && (state_q != RUN);
  assign cfg_ok   = len_legal(int'(bus.cfg_len), MAX_LEN);
  assign shift_en = (state_q == RUN) && bus.in_valid;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  seq_shift_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shift_cmp (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (hist_clear),
    .shift_i    (shift_en),
    .bit_i      (bus.in_bit),
    .len_i      (len_q),
    .pattern_i  (pat_q),
    .hit_next_o (hit_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  // abort outranks start and any hit landing on the same edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    match_d    = 1'b0;
    hist_clear = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.start && cfg_loaded_q) begin
          state_d    = RUN;
          cnt_d      = '0;
          hist_clear = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (hit_next) begin
          match_d    = 1'b1;
          cnt_d      = cnt_inc;
          hist_clear = !ovl_q;
          if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // config only lands outside RUN, so a running detection never sees it change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_loaded_q <= 1'b0;
      pat_q        <= '0;
      len_q        <= '0;
      ovl_q        <= 1'b0;
      tgt_q        <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_err_q <= cfg_acc && !cfg_ok;
      if (cfg_acc && cfg_ok) begin
        cfg_loaded_q <= 1'b1;
        pat_q        <= bus.cfg_pattern;
        len_q        <= bus.cfg_len;
        ovl_q        <= bus.cfg_overlap;
        tgt_q        <= bus.cfg_target;
      end
    end
  end

  assign bus.cfg_ready   = (state_q != RUN);
  assign bus.cfg_err     = cfg_err_q;
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.match       = match_q;
  assign bus.match_count = cnt_q;

endmodule
